// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package serial_adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/cla_slice_4bit.sv
// Combinational 4-bit carry-look-ahead slice; also exposes the carry into bit 3
// so the top can derive signed overflow on the most significant nibble.
module cla_slice_4bit
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co,
  output logic                c3
);
  logic [NIBBLE_W-1:0] g, p;
  logic c1, c2;

  assign g = a4 & b4;
  assign p = a4 ^ b4;

  // Every carry is a flat two-level function of g/p/ci; no ripple inside the slice.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s4 = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/serial_nibble_adder.sv
// WIDTH-bit adder processing one nibble per clock through a single CLA slice.
// Define OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_EN
  ,output logic            ovf
`endif
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, busy_q, done_q, cout_q;
  logic [NIBBLE_W-1:0] slice_s;
  logic               slice_co, slice_c3;

  assign idx_d = idx_q + 1'b1;

  cla_slice_4bit u_slice (
    .a4 (a_q[{idx_q, 2'b00} +: NIBBLE_W]),
    .b4 (b_q[{idx_q, 2'b00} +: NIBBLE_W]),
    .ci (carry_q),
    .s4 (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

`ifdef OVERFLOW_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  wire unused_c3 = slice_c3;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx_q, 2'b00} +: NIBBLE_W] <= slice_s;
          carry_q <= slice_co;
          if (idx_q == LAST) begin
            // idx stays at LAST; it is cleared on the next accepted start.
            cout_q  <= slice_co;
`ifdef OVERFLOW_EN
            ovf_q   <= slice_c3 ^ slice_co;
`endif
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder with a result scoreboard.
module tb_serial_nibble_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef OVERFLOW_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_done = 0;
  int   n_exp = 0;

  always #5 clk = ~clk;

  serial_nibble_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef OVERFLOW_EN
    ,.ovf (ovf)
`endif
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [W:0] t;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding start.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      chk("done_has_expectation", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sum", sum, mon_e.sum);
        chk("cout", cout, mon_e.cout);
`ifdef OVERFLOW_EN
        chk("ovf", ovf, mon_e.ovf);
`endif
      end
    end
  end

  // Drives start in the current cycle; returns just after the sampling edge.
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                             input bit push);
    a = x; b = y; cin = c; start = 1'b1;
    if (push) begin
      sb.push_back(model(x, y, c));
      n_exp++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    drive_start(x, y, c, 1'b1);
  endtask

  // Returns on the negedge where done is seen, or flags a timeout.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;

    // Reset asserted after two nibbles discards the operation
    do_start(16'h1357, 16'h2468, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("partial_sum", sum, 16'h00BF);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    void'(sb.pop_back());
    n_exp--;
    #1;
    chk("midrst_sum", sum, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic add with exact busy/done timing
    do_start(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
    end
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);

    // Carry ripples across every nibble boundary
    do_start(16'hFFFF, 16'h0001, 1'b0);
    wait_done("ripple");

    // cin-driven carry, then back-to-back start in the done cycle
    do_start(16'h0000, 16'hFFFF, 1'b1);
    wait_done("cin");
    drive_start(16'h0001, 16'h0001, 1'b0, 1'b1);
    wait_done("b2b");
    repeat (3) @(negedge clk);
    chk("hold_sum", sum, 16'h0002);
    chk("hold_done", done, 0);

    // start during RUN is ignored
    do_start(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 16'hF0F0; b = 16'h0F0F; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore");
    repeat (8) @(negedge clk);
    chk("ignore_sum", sum, 16'h3333);

`ifdef OVERFLOW_EN
    do_start(16'h7FFF, 16'h0001, 1'b0);
    wait_done("ovf_pos");
    chk("ovf_set", ovf, 1);
    do_start(16'hFFFF, 16'h0001, 1'b0);
    wait_done("ovf_neg");
    chk("ovf_clear", ovf, 0);
`endif

    for (int i = 0; i < 4; i++) begin
      do_start(W'($urandom), W'($urandom), 1'($urandom));
      wait_done("rand");
    end

    repeat (4) @(negedge clk);
    chk("done_count", n_done, n_exp);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
